and_datapath: RTL and testbench
===============================

Name: and_datapath

Overview:
- Single-bus 32-bit CPU datapath slice for the bring-up of the AND instruction (e.g. "and R1, R2, R3").
- Holds PC, IR, MAR, MDR, Y, Z (64-bit; low half drivable onto the bus) and general registers R1–R3, plus an ALU.
- All register transfers are controlled by discrete in/out strobes from an external control unit or testbench.
- Memory is modelled by the Mdatain input, captured into MDR when Read is asserted.

Parameters:
- WIDTH, 32, data/bus/register width; Z is 2*WIDTH.

Ports:
Clock  input  1  system clock; all register loads on rising edge
clear  input  1  asynchronous active-high reset; last port in the port list
PCout  input  1  drive PC onto bus
Zlowout  input  1  drive Z[WIDTH-1:0] onto bus
MDRout  input  1  drive MDR onto bus
R2out  input  1  drive R2 onto bus
R3out  input  1  drive R3 onto bus
MARin  input  1  load MAR from bus
Zin  input  1  load Z from ALU result
PCin  input  1  load PC from bus
MDRin  input  1  load MDR from MDR-input mux
IRin  input  1  load IR from bus
Yin  input  1  load Y from bus
IncPC  input  1  ALU op: result = bus + 1
Read  input  1  MDR-input mux select: 1 = Mdatain, 0 = bus
AND  input  1  ALU op: result = Y & bus
R1in  input  1  load R1 from bus
R2in  input  1  load R2 from bus
R3in  input  1  load R3 from bus
Mdatain  input  32  memory read data

Behaviour:
- Reset: clear high asynchronously forces PC, IR, MAR, MDR, Y, R1, R2, R3 to 0 and Z to 0. While clear is high, loads are ignored.
- Bus (combinational):
  - Out-strobes are nominally one-hot.
  - If several are high, fixed priority applies: MDRout > Zlowout > PCout > R2out > R3out.
  - If none is high, the bus is 0.
- MDR input mux: Read ? Mdatain : bus. MDR loads on a Clock rise when MDRin = 1. Read without MDRin changes nothing.
- Register loads:
  - Each of MAR, PC, IR, Y, R1, R2, R3 loads the bus value on a Clock rise when its in-strobe is 1.
  - Simultaneous loads of several registers from the same bus value are legal.
- ALU (combinational, 64-bit result C):
  - AND = 1: C = {0, Y & bus}. AND has priority over IncPC.
  - Else IncPC = 1: C = {0, bus + 1}; wraps 0xFFFFFFFF -> 0x00000000 with no carry into Z high.
  - Else: C = 0.
- Z loads C on a Clock rise when Zin = 1.
- Read-modify cycles:
  - Registers sample the bus value present before the edge.
  - Example: PCout, PCin, IncPC and Zin asserted together load PC with the old PC and Z with old PC + 1.
- One-cycle latency from strobe assertion to register update; bus and ALU have no latency.
- No internal sequencing; the block has no state machine.

Optional Feature:
- Macro DATAPATH_TRACE_EN.
- When defined: on every Clock rise with any in-strobe asserted, a simulation-only message prints time, destination register(s) and new value. Not synthesised.
- When undefined: no messages. Functional behaviour is identical in both cases.

Test Plan:
- Reset: pulse clear mid-cycle after loading R2 = 0x12 -> all registers read 0 immediately, without waiting for a Clock edge.
- Register preload: Mdatain = 0x12, Read + MDRin for one cycle; then MDRout + R2in -> R2 = 0x00000012. Repeat with 0x14 -> R3 and 0x18 -> R1.
- Fetch:
  - PC = 0, cycle T0: PCout + MARin + IncPC + Zin -> MAR = 0, Z = 1.
  - T1: Zlowout + PCin + Read + MDRin with Mdatain = 0x28918000 -> PC = 1, MDR = 0x28918000.
  - T2: MDRout + IRin -> IR = 0x28918000.
- AND execute (strobes one-hot, de-asserted each cycle):
  - T3: R2out + Yin -> Y = 0x12.
  - T4: R3out + AND + Zin -> Z = 0x10.
  - T5: Zlowout + R1in -> R1 = 0x00000010 (was 0x18).
- Priority and defaults:
  - MDRout and R2out both high with Yin -> Y = MDR.
  - No out-strobe with R1in -> R1 = 0.
  - AND and IncPC both high -> Z = Y & bus.
- Wrap: PC = 0xFFFFFFFF, PCout + IncPC + Zin -> Z = 0x0000000000000000.

Source files
------------

// File: rtl/and_datapath.sv
// Single-bus 32-bit datapath slice (PC, IR, MAR, MDR, Y, Z, R1-R3, ALU) for AND-instruction bring-up.
// Optional macro DATAPATH_TRACE_EN adds a simulation-only register-transfer trace; default build omits it.
module and_datapath #(
    parameter int WIDTH = 32
) (
    input  logic                 Clock,
    input  logic                 PCout,
    input  logic                 Zlowout,
    input  logic                 MDRout,
    input  logic                 R2out,
    input  logic                 R3out,
    input  logic                 MARin,
    input  logic                 Zin,
    input  logic                 PCin,
    input  logic                 MDRin,
    input  logic                 IRin,
    input  logic                 Yin,
    input  logic                 IncPC,
    input  logic                 Read,
    input  logic                 AND,
    input  logic                 R1in,
    input  logic                 R2in,
    input  logic                 R3in,
    input  logic [WIDTH-1:0]     Mdatain,
    output logic [WIDTH-1:0]     BusMuxOut_o,
    output logic [WIDTH-1:0]     PC_o,
    output logic [WIDTH-1:0]     IR_o,
    output logic [WIDTH-1:0]     MAR_o,
    output logic [WIDTH-1:0]     MDR_o,
    output logic [WIDTH-1:0]     Y_o,
    output logic [2*WIDTH-1:0]   Z_o,
    output logic [WIDTH-1:0]     R1_o,
    output logic [WIDTH-1:0]     R2_o,
    output logic [WIDTH-1:0]     R3_o,
    input  logic                 clear
);

    logic [WIDTH-1:0]   pc_q,  pc_d;
    logic [WIDTH-1:0]   ir_q,  ir_d;
    logic [WIDTH-1:0]   mar_q, mar_d;
    logic [WIDTH-1:0]   mdr_q, mdr_d;
    logic [WIDTH-1:0]   y_q,   y_d;
    logic [2*WIDTH-1:0] z_q,   z_d;
    logic [WIDTH-1:0]   r1_q,  r1_d;
    logic [WIDTH-1:0]   r2_q,  r2_d;
    logic [WIDTH-1:0]   r3_q,  r3_d;

    logic [WIDTH-1:0]   bus;
    logic [WIDTH-1:0]   mdr_mux;
    logic [WIDTH-1:0]   bus_inc;
    logic [2*WIDTH-1:0] alu_c;

    // Out-strobes should be one-hot; the priority chain keeps a collision deterministic.
    always_comb begin
        bus = '0;
        if (MDRout) begin
            bus = mdr_q;
        end else if (Zlowout) begin
            bus = z_q[WIDTH-1:0];
        end else if (PCout) begin
            bus = pc_q;
        end else if (R2out) begin
            bus = r2_q;
        end else if (R3out) begin
            bus = r3_q;
        end
    end

    assign mdr_mux = Read ? Mdatain : bus;

    // Increment is WIDTH bits wide so the carry out is dropped rather than reaching Z high.
    assign bus_inc = bus + {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        alu_c = '0;
        if (AND) begin
            alu_c = {{WIDTH{1'b0}}, y_q & bus};
        end else if (IncPC) begin
            alu_c = {{WIDTH{1'b0}}, bus_inc};
        end
    end

    always_comb begin
        pc_d  = PCin  ? bus     : pc_q;
        ir_d  = IRin  ? bus     : ir_q;
        mar_d = MARin ? bus     : mar_q;
        mdr_d = MDRin ? mdr_mux : mdr_q;
        y_d   = Yin   ? bus     : y_q;
        z_d   = Zin   ? alu_c   : z_q;
        r1_d  = R1in  ? bus     : r1_q;
        r2_d  = R2in  ? bus     : r2_q;
        r3_d  = R3in  ? bus     : r3_q;
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
            r1_q  <= '0;
            r2_q  <= '0;
            r3_q  <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            z_q   <= z_d;
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            r3_q  <= r3_d;
        end
    end

    assign BusMuxOut_o = bus;
    assign PC_o        = pc_q;
    assign IR_o        = ir_q;
    assign MAR_o       = mar_q;
    assign MDR_o       = mdr_q;
    assign Y_o         = y_q;
    assign Z_o         = z_q;
    assign R1_o        = r1_q;
    assign R2_o        = r2_q;
    assign R3_o        = r3_q;

`ifdef DATAPATH_TRACE_EN
    // $strobe reports after the edge has settled, so the printed values are the newly loaded ones.
    always @(posedge Clock) begin
        if (!clear) begin
            if (PCin)  $strobe("%0t: PC  <= %h", $time, pc_q);
            if (IRin)  $strobe("%0t: IR  <= %h", $time, ir_q);
            if (MARin) $strobe("%0t: MAR <= %h", $time, mar_q);
            if (MDRin) $strobe("%0t: MDR <= %h", $time, mdr_q);
            if (Yin)   $strobe("%0t: Y   <= %h", $time, y_q);
            if (Zin)   $strobe("%0t: Z   <= %h", $time, z_q);
            if (R1in)  $strobe("%0t: R1  <= %h", $time, r1_q);
            if (R2in)  $strobe("%0t: R2  <= %h", $time, r2_q);
            if (R3in)  $strobe("%0t: R3  <= %h", $time, r3_q);
        end
    end
`endif

endmodule

// File: tb/tb_and_datapath.sv
// Directed table-driven bench for and_datapath: preload, fetch, AND execute, priority, wrap and async clear.
module tb_and_datapath;

    localparam int W = 32;

    localparam logic [16:0] PCO  = 17'h00001;
    localparam logic [16:0] ZLO  = 17'h00002;
    localparam logic [16:0] MDO  = 17'h00004;
    localparam logic [16:0] R2O  = 17'h00008;
    localparam logic [16:0] R3O  = 17'h00010;
    localparam logic [16:0] MARI = 17'h00020;
    localparam logic [16:0] ZI   = 17'h00040;
    localparam logic [16:0] PCI  = 17'h00080;
    localparam logic [16:0] MDI  = 17'h00100;
    localparam logic [16:0] IRI  = 17'h00200;
    localparam logic [16:0] YI   = 17'h00400;
    localparam logic [16:0] INC  = 17'h00800;
    localparam logic [16:0] RD   = 17'h01000;
    localparam logic [16:0] ANDO = 17'h02000;
    localparam logic [16:0] R1I  = 17'h04000;
    localparam logic [16:0] R2I  = 17'h08000;
    localparam logic [16:0] R3I  = 17'h10000;

    localparam int S_NONE = 0, S_PC = 1, S_IR = 2, S_MAR = 3, S_MDR = 4,
                   S_Y = 5, S_Z = 6, S_R1 = 7, S_R2 = 8, S_R3 = 9;

    typedef struct {
        string       name;
        logic [16:0] ctl;
        logic [31:0] md;
        int          s1;
        logic [63:0] e1;
        int          s2;
        logic [63:0] e2;
    } vec_t;

    logic Clock = 1'b0;
    logic clear;
    logic PCout, Zlowout, MDRout, R2out, R3out, MARin, Zin, PCin, MDRin, IRin;
    logic Yin, IncPC, Read, AND, R1in, R2in, R3in;
    logic [W-1:0]   Mdatain;
    logic [W-1:0]   BusMuxOut_o, PC_o, IR_o, MAR_o, MDR_o, Y_o, R1_o, R2_o, R3_o;
    logic [2*W-1:0] Z_o;

    int checks = 0;
    int passed = 0;
    vec_t vecs[$];

    always #5 Clock = ~Clock;

    and_datapath #(.WIDTH(W)) dut (
        .Clock(Clock), .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
        .R2out(R2out), .R3out(R3out), .MARin(MARin), .Zin(Zin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
        .AND(AND), .R1in(R1in), .R2in(R2in), .R3in(R3in), .Mdatain(Mdatain),
        .BusMuxOut_o(BusMuxOut_o), .PC_o(PC_o), .IR_o(IR_o), .MAR_o(MAR_o),
        .MDR_o(MDR_o), .Y_o(Y_o), .Z_o(Z_o), .R1_o(R1_o), .R2_o(R2_o),
        .R3_o(R3_o), .clear(clear)
    );

    task automatic set_ctl(input logic [16:0] c, input logic [31:0] md);
        PCout = c[0];  Zlowout = c[1]; MDRout = c[2];  R2out = c[3];
        R3out = c[4];  MARin = c[5];   Zin = c[6];     PCin = c[7];
        MDRin = c[8];  IRin = c[9];    Yin = c[10];    IncPC = c[11];
        Read = c[12];  AND = c[13];    R1in = c[14];   R2in = c[15];
        R3in = c[16];  Mdatain = md;
    endtask

    function automatic logic [63:0] get_reg(input int sel);
        case (sel)
            S_PC:    return {32'h0, PC_o};
            S_IR:    return {32'h0, IR_o};
            S_MAR:   return {32'h0, MAR_o};
            S_MDR:   return {32'h0, MDR_o};
            S_Y:     return {32'h0, Y_o};
            S_Z:     return Z_o;
            S_R1:    return {32'h0, R1_o};
            S_R2:    return {32'h0, R2_o};
            S_R3:    return {32'h0, R3_o};
            default: return 64'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_all_zero(input string tag);
        for (int s = S_PC; s <= S_R3; s++)
            check($sformatf("%s reg%0d", tag, s), get_reg(s), 64'h0);
    endtask

    function automatic vec_t mk(input string n, input logic [16:0] c, input logic [31:0] md,
                                input int s1, input logic [63:0] e1,
                                input int s2, input logic [63:0] e2);
        vec_t v;
        v.name = n; v.ctl = c; v.md = md; v.s1 = s1; v.e1 = e1; v.s2 = s2; v.e2 = e2;
        return v;
    endfunction

    initial begin
        // Preload, fetch, AND execute, priority/default and wrap cases, in execution order.
        vecs.push_back(mk("ld_mdr_12",  RD|MDI,          32'h12, S_MDR, 64'h12, S_NONE, 0));
        vecs.push_back(mk("r2_12",      MDO|R2I,         0,      S_R2,  64'h12, S_NONE, 0));
        vecs.push_back(mk("ld_mdr_14",  RD|MDI,          32'h14, S_MDR, 64'h14, S_NONE, 0));
        vecs.push_back(mk("r3_14",      MDO|R3I,         0,      S_R3,  64'h14, S_NONE, 0));
        vecs.push_back(mk("ld_mdr_18",  RD|MDI,          32'h18, S_MDR, 64'h18, S_NONE, 0));
        vecs.push_back(mk("r1_18",      MDO|R1I,         0,      S_R1,  64'h18, S_NONE, 0));
        vecs.push_back(mk("t0",         PCO|MARI|INC|ZI, 0,      S_MAR, 64'h0,  S_Z, 64'h1));
        vecs.push_back(mk("t1",         ZLO|PCI|RD|MDI,  32'h28918000, S_PC, 64'h1, S_MDR, 64'h28918000));
        vecs.push_back(mk("t2",         MDO|IRI,         0,      S_IR,  64'h28918000, S_NONE, 0));
        vecs.push_back(mk("rmw_pc",     PCO|PCI|INC|ZI,  0,      S_PC,  64'h1,  S_Z, 64'h2));
        vecs.push_back(mk("t3",         R2O|YI,          0,      S_Y,   64'h12, S_NONE, 0));
        vecs.push_back(mk("t4",         R3O|ANDO|ZI,     0,      S_Z,   64'h10, S_NONE, 0));
        vecs.push_back(mk("t5",         ZLO|R1I,         0,      S_R1,  64'h10, S_NONE, 0));
        vecs.push_back(mk("and_over_inc", R2O|ANDO|INC|ZI, 0,    S_Z,   64'h12, S_NONE, 0));
        vecs.push_back(mk("zlo_over_pc",  ZLO|PCO|R3I,   0,      S_R3,  64'h12, S_NONE, 0));
        vecs.push_back(mk("mdr_over_r2",  MDO|R2O|YI,    0,      S_Y,   64'h28918000, S_NONE, 0));
        vecs.push_back(mk("bus_default",  R1I,           0,      S_R1,  64'h0,  S_NONE, 0));
        vecs.push_back(mk("read_no_mdrin", RD,           32'hDEADBEEF, S_MDR, 64'h28918000, S_NONE, 0));
        vecs.push_back(mk("ld_mdr_ff",  RD|MDI,          32'hFFFFFFFF, S_MDR, 64'hFFFFFFFF, S_NONE, 0));
        vecs.push_back(mk("pc_ff",      MDO|PCI,         0,      S_PC,  64'hFFFFFFFF, S_NONE, 0));
        vecs.push_back(mk("wrap",       PCO|INC|ZI,      0,      S_Z,   64'h0,  S_PC, 64'hFFFFFFFF));

        set_ctl('0, '0);
        clear = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        check_all_zero("reset");
        @(negedge Clock);
        clear = 1'b0;

        foreach (vecs[i]) begin
            @(negedge Clock);
            set_ctl(vecs[i].ctl, vecs[i].md);
            @(posedge Clock);
            #1;
            set_ctl('0, '0);
            check(vecs[i].name, get_reg(vecs[i].s1), vecs[i].e1);
            if (vecs[i].s2 != S_NONE)
                check({vecs[i].name, "_b"}, get_reg(vecs[i].s2), vecs[i].e2);
        end

        // Reload R2, then pulse clear mid-cycle: registers must drop without a clock edge.
        @(negedge Clock);
        set_ctl(RD|MDI, 32'h12);
        @(negedge Clock);
        set_ctl(MDO|R2I, 0);
        @(posedge Clock);
        #1;
        set_ctl('0, '0);
        check("r2_before_clear", {32'h0, R2_o}, 64'h12);
        #2;
        clear = 1'b1;
        #1;
        check_all_zero("async_clear");

        // Loads are ignored while clear is held across an edge.
        set_ctl(RD|MDI|PCO|PCI|INC|ZI, 32'h55);
        @(posedge Clock);
        #1;
        check("mdr_held_in_clear", {32'h0, MDR_o}, 64'h0);
        check("z_held_in_clear", Z_o, 64'h0);
        set_ctl('0, '0);
        @(negedge Clock);
        clear = 1'b0;

        @(negedge Clock);
        set_ctl(RD|MDI, 32'hA5A5A5A5);
        @(posedge Clock);
        #1;
        set_ctl('0, '0);
        check("load_after_clear", {32'h0, MDR_o}, 64'hA5A5A5A5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
